// File: rtl/serial_add_sched.sv
// serial_add_sched
//   Bit-serial adder shared between two requesters. A single full-adder cell
//   processes one operand bit per clock, LSB first, with the carry kept in a
//   flop. Grants in IDLE alternate between requesters when both are valid.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      operand handshake per requester
//   req{0,1}_a/_b/_cin         operands and carry-in (sampled on acceptance)
//   rsp_valid/rsp_ready        result handshake
//   rsp_sum, rsp_cout, rsp_id  W-bit sum, carry-out, owning requester
//   busy                       high while an operation is in RUN or DONE
module serial_add_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic          fa_s, fa_c;
  logic          grant0, grant1;

  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // On a tie the requester that did not win last time is granted.
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          carry_d = req0_cin;
          id_d    = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          carry_d = req1_cin;
          id_d    = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        // Shift-then-insert keeps the W=1 case free of empty slices.
        acc_d      = acc_q >> 1;
        acc_d[W-1] = fa_s;
        carry_d    = fa_c;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          sum_d   = acc_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
module tb_serial_add_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- W = 8 instance ----------------
  logic       rst_n;
  logic       r0v, r1v, r0c, r1c, rr;
  logic [7:0] r0a, r0b, r1a, r1b;
  logic       r0rdy, r1rdy, rvalid, rcout, rid, rbusy;
  logic [7:0] rsum;

  serial_add_sched #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
    .rsp_valid(rvalid), .rsp_ready(rr), .rsp_sum(rsum), .rsp_cout(rcout),
    .rsp_id(rid), .busy(rbusy)
  );

  // Reference: winner of the previous grant (1 after reset so req0 wins a tie).
  bit m_last = 1'b1;

  // Called at a negedge with the DUT in IDLE and requester inputs set up.
  task automatic run_op(input int hold, input bit drop);
    bit         win;
    logic [8:0] e;
    int         lat;
    #1;
    if (!r0v && !r1v) begin
      chk("idle_rdy", {r0rdy, r1rdy}, 0);
      @(posedge clk); @(negedge clk);
      chk("idle_busy", rbusy, 0);
      return;
    end
    win = (r0v && r1v) ? ~m_last : r1v;
    chk("rdy0", r0rdy, !win);
    chk("rdy1", r1rdy, win);
    e = win ? (9'(r1a) + 9'(r1b) + 9'(r1c)) : (9'(r0a) + 9'(r0b) + 9'(r0c));
    m_last = win;
    @(posedge clk); @(negedge clk);
    if (drop) begin
      r0v = 0; r1v = 0;
      r0a = 8'($urandom); r0b = 8'($urandom); r1a = 8'($urandom); r1b = 8'($urandom);
      r0c = 1'($urandom); r1c = 1'($urandom);
    end
    #1;
    chk("run_busy", rbusy, 1);
    chk("run_rdy", {r0rdy, r1rdy}, 0);
    lat = 0;
    while (!rvalid && lat < 14) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("latency", lat, 8);
    chk("sum", {rcout, rsum}, e);
    chk("id", rid, win);
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", rvalid, 1);
      chk("hold_data", {rid, rcout, rsum}, {win, e});
      chk("hold_rdy", {r0rdy, r1rdy}, 0);
    end
    rr = 1; #1;
    chk("hs_rdy", {r0rdy, r1rdy}, 0);
    @(posedge clk); @(negedge clk);
    rr = 0;
    chk("post_valid", rvalid, 0);
    chk("post_busy", rbusy, 0);
  endtask

  // ---------------- W = 1 instance ----------------
  logic rst1_n;
  logic q0v, q1v, q0a, q0b, q0c, q1a, q1b, q1c, qrr;
  logic q0rdy, q1rdy, qvalid, qsum, qcout, qid, qbusy;
  bit   done1 = 1'b0;

  serial_add_sched #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .req0_valid(q0v), .req0_ready(q0rdy), .req0_a(q0a), .req0_b(q0b), .req0_cin(q0c),
    .req1_valid(q1v), .req1_ready(q1rdy), .req1_a(q1a), .req1_b(q1b), .req1_cin(q1c),
    .rsp_valid(qvalid), .rsp_ready(qrr), .rsp_sum(qsum), .rsp_cout(qcout),
    .rsp_id(qid), .busy(qbusy)
  );

  initial begin : w1_proc
    bit         l1, w1;
    logic [1:0] e1;
    int         lat1;
    {q0v, q1v, q0a, q0b, q0c, q1a, q1b, q1c, qrr} = '0;
    l1 = 1'b1;
    rst1_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1_n = 1;
    for (int i = 0; i < 1000; i++) begin
      q0v = 1'($urandom); q1v = 1'($urandom);
      if (!q0v && !q1v) q0v = 1;
      {q0a, q0b, q0c, q1a, q1b, q1c} = 6'($urandom);
      #1;
      w1 = (q0v && q1v) ? ~l1 : q1v;
      chk("w1_rdy", {q0rdy, q1rdy}, {!w1, w1});
      e1 = w1 ? (2'(q1a) + 2'(q1b) + 2'(q1c)) : (2'(q0a) + 2'(q0b) + 2'(q0c));
      l1 = w1;
      @(posedge clk); @(negedge clk);
      q0v = 0; q1v = 0;
      {q0a, q0b, q0c, q1a, q1b, q1c} = 6'($urandom);
      lat1 = 0;
      while (!qvalid && lat1 < 6) begin
        @(posedge clk); @(negedge clk);
        lat1++;
      end
      chk("w1_latency", lat1, 1);
      chk("w1_result", {qid, qcout, qsum}, {w1, e1});
      qrr = 1;
      @(posedge clk); @(negedge clk);
      qrr = 0;
      chk("w1_post", {qvalid, qbusy}, 0);
    end
    done1 = 1'b1;
  end

  // ---------------- main sequence (W = 8) ----------------
  initial begin
    int w;
    {r0v, r1v, r0c, r1c, rr} = '0;
    {r0a, r0b, r1a, r1b} = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {rvalid, rsum, rcout, rid, rbusy}, 0);
    rst_n = 1;

    // Both requesters valid continuously: grants must alternate 0,1,0,1.
    r0v = 1; r1v = 1; r1a = 8'h80; r1b = 8'h90; r1c = 1;
    for (int i = 0; i < 4; i++) begin
      r0a = 8'(8'h11 + i); r0b = 8'h22; r0c = 0;
      r1a = 8'(8'h80 + 3 * i);
      run_op(0, 0);
    end
    r0v = 0; r1v = 0;
    @(posedge clk); @(negedge clk);

    // Directed arithmetic cases.
    r0v = 1; r0a = 8'h5A; r0b = 8'h3C; r0c = 0;
    run_op(0, 1);
    r1v = 1; r1a = 8'hFF; r1b = 8'h01; r1c = 0;
    run_op(0, 1);
    r1v = 1; r1a = 8'hFF; r1b = 8'h00; r1c = 1;
    run_op(0, 1);

    // Consumer stalls 5 cycles; the next request is accepted right after.
    r0v = 1; r1v = 1; r0a = 8'hC3; r0b = 8'h7E; r0c = 1; r1a = 8'h01; r1b = 8'h02; r1c = 0;
    run_op(5, 0);
    run_op(0, 1);

    // Reset during RUN cycle 3 aborts the operation.
    r0v = 1; r0a = 8'hAA; r0b = 8'h55; r0c = 1;
    #1;
    chk("abort_rdy", r0rdy, 1);
    @(posedge clk); @(negedge clk);
    r0v = 0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 0; #1;
    chk("abort_out", {rvalid, rsum, rcout, rid, rbusy}, 0);
    m_last = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_novalid", {rvalid, rbusy}, 0);
    end
    r0v = 1; r1v = 1; r0a = 8'h12; r0b = 8'h34; r0c = 0; r1a = 8'h56; r1b = 8'h78; r1c = 1;
    run_op(0, 1);

    // Randomised traffic.
    for (int i = 0; i < 1000; i++) begin
      r0v = 1'($urandom); r1v = 1'($urandom);
      r0a = 8'($urandom); r0b = 8'($urandom); r0c = 1'($urandom);
      r1a = 8'($urandom); r1b = 8'($urandom); r1c = 1'($urandom);
      run_op(int'($urandom_range(0, 2)), 1'($urandom));
    end
    r0v = 0; r1v = 0;

    w = 0;
    while (!done1 && w < 20000) begin
      @(posedge clk);
      w++;
    end
    chk("w1_done", done1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
